// File: rtl/fast_control_rx.sv
// Fast-control link receiver: Hamming(8,4) SEC-DED decode, pulse regeneration and BCR orbit lock.
// Optional orbit counter built when FAST_CONTROL_RX_ORBIT_COUNT_EN is defined.
module fast_control_rx #(
    parameter int unsigned LOCK_COUNT   = 4,
    parameter int unsigned UNLOCK_COUNT = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk_bx,
    input  logic             reset,
    input  logic [15:0]      fc_stream_enc,
    input  logic [11:0]      orb_length,
    input  logic             clear_counters,
    output logic             bcr,
    output logic             l1a,
    output logic             link_reset,
    output logic             buffer_clear,
    output logic [3:0]       debug_bits,
    output logic [11:0]      bx_count,
    output logic             locked,
    output logic [CNT_W-1:0] sec_count,
    output logic [CNT_W-1:0] ded_count,
    output logic [CNT_W-1:0] bcr_err_count,
    output logic [31:0]      orbit_count
);

    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned MISS_W = $clog2(UNLOCK_COUNT + 1);
    localparam int unsigned SUM_W  = CNT_W + 1;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKING  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    // Returns {ded, sec, d3, d2, d1, d0} for one code byte.
    function automatic logic [5:0] hamming84_dec(input logic [7:0] b);
        logic [2:0] syn;
        logic       p_bad;
        logic [7:0] c;
        logic       sec;
        logic       ded;
        syn   = {b[3] ^ b[4] ^ b[5] ^ b[6],
                 b[1] ^ b[2] ^ b[5] ^ b[6],
                 b[0] ^ b[2] ^ b[4] ^ b[6]};
        p_bad = ^b;
        c     = b;
        sec   = 1'b0;
        ded   = 1'b0;
        if (syn != 3'd0 && p_bad) begin
            c   = b ^ (8'd1 << (syn - 3'd1));
            sec = 1'b1;
        end else if (syn == 3'd0 && p_bad) begin
            sec = 1'b1;
        end else if (syn != 3'd0 && !p_bad) begin
            ded = 1'b1;
        end
        return {ded, sec, c[6], c[5], c[4], c[2]};
    endfunction

    state_t            state, state_nxt;
    logic [GOOD_W-1:0] good, good_nxt;
    logic [MISS_W-1:0] miss, miss_nxt;
    logic [11:0]       bx_nxt;
    logic [15:0]       enc_q;

    logic [5:0]        dec_lo_c, dec_hi_c;
    logic              cmd_ok_c, bcr_dec_c, wrap_c, err_inc_c;
    logic [11:0]       bx_inc_c;
    logic [1:0]        sec_inc_c, ded_inc_c;
    logic [SUM_W-1:0]  sec_sum_c, ded_sum_c;

    // Decode and counter arithmetic
    always_comb begin
        dec_lo_c  = hamming84_dec(enc_q[7:0]);
        dec_hi_c  = hamming84_dec(enc_q[15:8]);
        cmd_ok_c  = !dec_lo_c[5];
        bcr_dec_c = cmd_ok_c && dec_lo_c[0];
        bx_inc_c  = bx_count + 12'd1;
        wrap_c    = (bx_inc_c == orb_length);
        sec_inc_c = 2'(dec_lo_c[4]) + 2'(dec_hi_c[4]);
        ded_inc_c = 2'(dec_lo_c[5]) + 2'(dec_hi_c[5]);
        sec_sum_c = {1'b0, sec_count} + SUM_W'(sec_inc_c);
        ded_sum_c = {1'b0, ded_count} + SUM_W'(ded_inc_c);
    end

    // Lock state register
    always_ff @(posedge clk_bx) begin
        if (reset) begin
            state <= ST_UNLOCKED;
            good  <= '0;
            miss  <= '0;
        end else begin
            state <= state_nxt;
            good  <= good_nxt;
            miss  <= miss_nxt;
        end
    end

    // Lock next-state; the counter realigns only outside LOCKED
    always_comb begin
        state_nxt = state;
        good_nxt  = good;
        miss_nxt  = miss;
        bx_nxt    = wrap_c ? 12'd0 : bx_inc_c;
        err_inc_c = 1'b0;
        case (state)
            ST_UNLOCKED: begin
                if (bcr_dec_c) begin
                    bx_nxt    = 12'd0;
                    good_nxt  = GOOD_W'(1);
                    state_nxt = ST_LOCKING;
                end
            end
            ST_LOCKING: begin
                if (bcr_dec_c && wrap_c) begin
                    good_nxt = good + GOOD_W'(1);
                    if (good_nxt >= GOOD_W'(LOCK_COUNT)) begin
                        state_nxt = ST_LOCKED;
                        miss_nxt  = '0;
                    end
                end else if (bcr_dec_c) begin
                    bx_nxt   = 12'd0;
                    good_nxt = GOOD_W'(1);
                end else if (wrap_c) begin
                    good_nxt  = '0;
                    state_nxt = ST_UNLOCKED;
                end
            end
            ST_LOCKED: begin
                if (bcr_dec_c && wrap_c) begin
                    miss_nxt = '0;
                end else if (bcr_dec_c || wrap_c) begin
                    err_inc_c = 1'b1;
                    miss_nxt  = miss + MISS_W'(1);
                    if (miss_nxt >= MISS_W'(UNLOCK_COUNT)) begin
                        miss_nxt  = '0;
                        good_nxt  = '0;
                        state_nxt = ST_UNLOCKED;
                    end
                end
            end
            default: begin
                state_nxt = ST_UNLOCKED;
                good_nxt  = '0;
                miss_nxt  = '0;
            end
        endcase
    end

    // Input stage, pulse/debug outputs and error counters
    always_ff @(posedge clk_bx) begin
        if (reset) begin
            enc_q         <= '0;
            bcr           <= 1'b0;
            l1a           <= 1'b0;
            link_reset    <= 1'b0;
            buffer_clear  <= 1'b0;
            debug_bits    <= '0;
            bx_count      <= '0;
            locked        <= 1'b0;
            sec_count     <= '0;
            ded_count     <= '0;
            bcr_err_count <= '0;
        end else begin
            enc_q        <= fc_stream_enc;
            bcr          <= bcr_dec_c;
            l1a          <= cmd_ok_c && dec_lo_c[1];
            link_reset   <= cmd_ok_c && dec_lo_c[2];
            buffer_clear <= cmd_ok_c && dec_lo_c[3];
            if (!dec_hi_c[5]) begin
                debug_bits <= dec_hi_c[3:0];
            end
            bx_count <= bx_nxt;
            locked   <= (state_nxt == ST_LOCKED);
            if (clear_counters) begin
                sec_count     <= '0;
                ded_count     <= '0;
                bcr_err_count <= '0;
            end else begin
                sec_count <= sec_sum_c[CNT_W] ? '1 : sec_sum_c[CNT_W-1:0];
                ded_count <= ded_sum_c[CNT_W] ? '1 : ded_sum_c[CNT_W-1:0];
                if (err_inc_c && (bcr_err_count != '1)) begin
                    bcr_err_count <= bcr_err_count + CNT_W'(1);
                end
            end
        end
    end

`ifdef FAST_CONTROL_RX_ORBIT_COUNT_EN
    logic        orbit_inc_c, orbit_clr_c;
    logic [31:0] orbit_q;

    // Aligned BCRs while locked; restarts whenever lock is lost
    always_comb begin
        orbit_inc_c = (state == ST_LOCKED) && bcr_dec_c && wrap_c;
        orbit_clr_c = (state != ST_UNLOCKED) && (state_nxt == ST_UNLOCKED);
    end

    always_ff @(posedge clk_bx) begin
        if (reset || orbit_clr_c) begin
            orbit_q <= '0;
        end else if (orbit_inc_c) begin
            orbit_q <= orbit_q + 32'd1;
        end
    end

    assign orbit_count = orbit_q;
`else
    assign orbit_count = '0;
`endif

endmodule
